// File: rtl/bbq_sched_pkg.sv
// Shared definitions for the bucket bitmap scheduler.
//   - state_e        : dequeue FSM states (IDLE -> FIND -> COMMIT -> IDLE)
//   - *_DEF          : default geometry (16 buckets, 8-bit occupancy counters)
//   - COUNT_MAX_DEF  : saturation value of a default-width occupancy counter
//   - helper functions deriving bucket count and total-count width
package bbq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIND   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int NUM_BUCKETS_LOG_DEF = 4;
  localparam int COUNT_WIDTH_DEF     = 8;
  localparam int COUNT_MAX_DEF       = (1 << COUNT_WIDTH_DEF) - 1;

  function automatic int num_buckets(input int log2n);
    return 1 << log2n;
  endfunction

  // Sum of all counters needs log2(buckets) extra bits so it can never wrap.
  function automatic int total_width(input int count_w, input int log2n);
    return count_w + log2n;
  endfunction

endpackage

// File: rtl/bucket_bitmap_scheduler_ffs.sv
// Find-first-set unit over a 2^WIDTH_LOG-bit vector.
//   vec  : input vector
//   lsb  : index of the lowest set bit (0 when vec is zero)
//   msb  : index of the highest set bit (0 when vec is zero)
//   zero : vec has no bit set
module bucket_bitmap_scheduler_ffs #(
  parameter int WIDTH_LOG = 4,
  localparam int WIDTH    = 1 << WIDTH_LOG
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [WIDTH_LOG-1:0] lsb,
  output logic [WIDTH_LOG-1:0] msb,
  output logic                 zero
);

  always_comb begin
    lsb  = '0;
    msb  = '0;
    zero = ~|vec;
    // Scanning downwards leaves the lowest set index as the last write.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) lsb = WIDTH_LOG'(i);
    end
    // Scanning upwards leaves the highest set index as the last write.
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) msb = WIDTH_LOG'(i);
    end
  end

endmodule

// File: rtl/bucket_bitmap_scheduler.sv
// Bucket occupancy tracker and min/max dequeue scheduler for a bucketed
// priority queue. Keeps one counter per bucket plus a non-empty bitmap, and
// answers each dequeue with the lowest (deq_max=0) or highest (deq_max=1)
// non-empty bucket, decrementing that bucket's count.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   enq_valid/ready/bucket   : enqueue handshake; ready drops for a full bucket
//   deq_valid/ready/max      : dequeue handshake; ready only while IDLE
//   resp_valid/bucket/empty  : one-cycle response two cycles after accept
//   bitmap                   : bit i set when bucket i is non-empty
//   total_count              : sum of all bucket counts
//   busy                     : a dequeue is in flight
module bucket_bitmap_scheduler
  import bbq_sched_pkg::*;
#(
  parameter int NUM_BUCKETS_LOG = NUM_BUCKETS_LOG_DEF,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF,
  localparam int NUM_BUCKETS    = num_buckets(NUM_BUCKETS_LOG),
  localparam int TOTAL_W        = total_width(COUNT_WIDTH, NUM_BUCKETS_LOG)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [NUM_BUCKETS_LOG-1:0] enq_bucket,
  input  logic                       deq_valid,
  output logic                       deq_ready,
  input  logic                       deq_max,
  output logic                       resp_valid,
  output logic [NUM_BUCKETS_LOG-1:0] resp_bucket,
  output logic                       resp_empty,
  output logic [NUM_BUCKETS-1:0]     bitmap,
  output logic [TOTAL_W-1:0]         total_count,
  output logic                       busy
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_e                     state_q, state_d;
  logic                       deq_max_p0;
  logic [NUM_BUCKETS_LOG-1:0] find_idx_p1;
  logic                       find_zero_p1;
  logic [COUNT_WIDTH-1:0]     count_q [NUM_BUCKETS];
  logic [TOTAL_W-1:0]         total_q;
  logic [NUM_BUCKETS_LOG-1:0] ffs_lsb, ffs_msb;
  logic                       ffs_zero;
  logic                       enq_fire, dec_fire;

  bucket_bitmap_scheduler_ffs #(
    .WIDTH_LOG (NUM_BUCKETS_LOG)
  ) u_ffs (
    .vec  (bitmap),
    .lsb  (ffs_lsb),
    .msb  (ffs_msb),
    .zero (ffs_zero)
  );

  always_comb begin
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      bitmap[i] = |count_q[i];
    end
  end

  assign enq_ready   = (count_q[enq_bucket] != COUNT_MAX);
  assign enq_fire    = enq_valid && enq_ready;
  assign dec_fire    = (state_q == COMMIT) && !find_zero_p1;
  assign total_count = total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    deq_ready   = 1'b0;
    busy        = 1'b1;
    resp_valid  = 1'b0;
    resp_bucket = '0;
    resp_empty  = 1'b0;
    case (state_q)
      IDLE: begin
        deq_ready = 1'b1;
        busy      = 1'b0;
        if (deq_valid) state_d = FIND;
      end
      FIND: begin
        state_d = COMMIT;
      end
      COMMIT: begin
        resp_valid  = 1'b1;
        resp_empty  = find_zero_p1;
        resp_bucket = find_zero_p1 ? '0 : find_idx_p1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stage p0: direction latched on accept
  always_ff @(posedge clk) begin
    if (state_q == IDLE && deq_valid) deq_max_p0 <= deq_max;
  end

  // Stage p1: search result over the bitmap as it stands in the FIND cycle;
  // an enqueue landing on this same edge is deliberately not seen.
  always_ff @(posedge clk) begin
    if (state_q == FIND) begin
      find_zero_p1 <= ffs_zero;
      find_idx_p1  <= ffs_zero ? '0 : (deq_max_p0 ? ffs_msb : ffs_lsb);
    end
  end

  // An enqueue and a commit-decrement on the same bucket cancel out, which
  // keeps the bucket's bitmap bit set throughout.
  for (genvar g = 0; g < NUM_BUCKETS; g++) begin : g_count
    logic inc, dec;
    assign inc = enq_fire && (enq_bucket == NUM_BUCKETS_LOG'(g));
    assign dec = dec_fire && (find_idx_p1 == NUM_BUCKETS_LOG'(g));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q[g] <= '0;
      end else if (inc && !dec) begin
        count_q[g] <= count_q[g] + 1'b1;
      end else if (dec && !inc) begin
        count_q[g] <= count_q[g] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else if (enq_fire && !dec_fire) begin
      total_q <= total_q + 1'b1;
    end else if (dec_fire && !enq_fire) begin
      total_q <= total_q - 1'b1;
    end
  end

  // The bitmap only selects non-empty buckets, so a decrement target is >= 1.
  always @(posedge clk) begin
    if (!rst && dec_fire) assert (count_q[find_idx_p1] != '0);
  end

endmodule

// File: tb/tb_bucket_bitmap_scheduler.sv
module tb_bucket_bitmap_scheduler;
  import bbq_sched_pkg::*;

  localparam int NB   = 16;
  localparam int CMAX = COUNT_MAX_DEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready;
  logic [3:0]  enq_bucket;
  logic        deq_valid, deq_ready, deq_max;
  logic        resp_valid, resp_empty;
  logic [3:0]  resp_bucket;
  logic [15:0] bitmap;
  logic [11:0] total_count;
  logic        busy;

  bucket_bitmap_scheduler #(
    .NUM_BUCKETS_LOG (4),
    .COUNT_WIDTH     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_bucket  (enq_bucket),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_max     (deq_max),
    .resp_valid  (resp_valid),
    .resp_bucket (resp_bucket),
    .resp_empty  (resp_empty),
    .bitmap      (bitmap),
    .total_count (total_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int bucket;
    int empty;
    int at;
  } exp_t;

  exp_t sbq[$];
  exp_t got;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: plain occupancy array plus "cycles since accept".
  int mc [NB];
  int phase;
  int pend_max, pend_bucket, pend_empty;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        got = sbq.pop_front();
        chk("resp_bucket", int'(resp_bucket), got.bucket);
        chk("resp_empty", int'(resp_empty), got.empty);
        chk("resp_cycle", cyc, got.at);
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_bucket = 4'd0;
    deq_valid = 1'b0;
    deq_max   = 1'b0;
    #1;
    sbq.delete();
    for (int i = 0; i < NB; i++) mc[i] = 0;
    phase = 0;
    chk("rst_bitmap", int'(bitmap), 0);
    chk("rst_total", int'(total_count), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_deq_ready", int'(deq_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enq_ready", int'(enq_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle, entered and left on a falling edge.
  task automatic step(input logic ev, input logic [3:0] eb, input logic dv, input logic dm);
    int exp_bm, exp_tot, pick, emp;
    logic enq_acc, deq_acc;
    exp_bm  = 0;
    exp_tot = 0;
    for (int i = 0; i < NB; i++) begin
      if (mc[i] != 0) exp_bm |= (1 << i);
      exp_tot += mc[i];
    end
    chk("bitmap", int'(bitmap), exp_bm);
    chk("total_count", int'(total_count), exp_tot);
    chk("deq_ready", int'(deq_ready), int'(phase == 0));
    chk("busy", int'(busy), int'(phase != 0));
    if (phase == 1) begin
      pick = 0;
      emp  = 1;
      for (int i = 0; i < NB; i++) begin
        if (mc[i] != 0) begin
          if (emp != 0 || pend_max != 0) pick = i;
          emp = 0;
        end
      end
      pend_bucket = pick;
      pend_empty  = emp;
      sbq.push_back('{bucket: pick, empty: emp, at: cyc + 1});
    end
    enq_valid  = ev;
    enq_bucket = eb;
    deq_valid  = dv;
    deq_max    = dm;
    #1;
    chk("enq_ready", int'(enq_ready), int'(mc[eb] != CMAX));
    enq_acc = ev && (mc[eb] != CMAX);
    deq_acc = dv && (phase == 0);
    @(posedge clk);
    if (enq_acc) mc[eb]++;
    if (phase == 2 && pend_empty == 0) mc[pend_bucket]--;
    case (phase)
      0: if (deq_acc) begin
           phase    = 1;
           pend_max = int'(dm);
         end
      1: phase = 2;
      default: phase = 0;
    endcase
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    enq_valid  = 1'b0;
    enq_bucket = 4'd0;
    deq_valid  = 1'b0;
    deq_max    = 1'b0;
    phase      = 0;
    pend_max   = 0;
    pend_bucket = 0;
    pend_empty = 1;
    @(negedge clk);
    do_reset();

    // Dequeue on an empty structure.
    repeat (3) step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);

    // Enqueue 5, 9, 9, 2 then three min dequeues -> 2, 5, 9.
    do_reset();
    step(1'b1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b1, 4'd9, 1'b0, 1'b0);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    repeat (9) step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("min_seq_bitmap", int'(bitmap), 32'h0200);
    chk("min_seq_total", int'(total_count), 1);

    // Max mode with buckets 3 and 12.
    do_reset();
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd12, 1'b0, 1'b0);
    repeat (3) step(1'b0, 4'd0, 1'b1, 1'b1);
    chk("max_bitmap", int'(bitmap), 32'h0008);

    // Saturate bucket 7, hold enqueue against it, then free one slot.
    do_reset();
    repeat (CMAX + 1) step(1'b1, 4'd7, 1'b0, 1'b0);
    chk("sat_total", int'(total_count), CMAX);
    chk("sat_enq_ready", int'(enq_ready), 0);
    step(1'b1, 4'd7, 1'b1, 1'b1);
    repeat (4) step(1'b1, 4'd7, 1'b0, 1'b0);
    chk("sat_refill_total", int'(total_count), CMAX);

    // Same-bucket enqueue during COMMIT, other-bucket enqueue during FIND.
    do_reset();
    step(1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd4, 1'b0, 1'b0);
    chk("collide_bitmap", int'(bitmap), 32'h0012);
    chk("collide_total", int'(total_count), 2);

    // Reset while the search is in FIND: request dropped, no response.
    do_reset();
    step(1'b1, 4'd6, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    do_reset();
    chk("midfind_deq_ready", int'(deq_ready), 1);
    repeat (3) step(1'b0, 4'd0, 1'b0, 1'b0);

    // Randomized traffic, concentrated on a few buckets to build depth.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0),
             ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      end
    end

    repeat (4) step(1'b0, 4'd0, 1'b0, 1'b0);
    chk("pending_resp", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bucket_bitmap_scheduler.md
Name: bucket_bitmap_scheduler

Overview:
Tracks per-bucket occupancy counts for a bucketed priority queue and keeps a one-bit-per-bucket non-empty bitmap. Serves dequeue requests by locating the lowest (min mode) or highest (max mode) non-empty bucket with the existing ffs find-first-set unit, then decrements that bucket's count. Sits between the enqueue/dequeue front-end and the bucket storage, which receives the chosen bucket index.

Parameters:
NUM_BUCKETS_LOG, 4, log2 of bucket count; NUM_BUCKETS = 1 << NUM_BUCKETS_LOG.
COUNT_WIDTH, 8, width of each per-bucket occupancy counter; max count is 2^COUNT_WIDTH - 1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
enq_valid  in  1  enqueue request
enq_ready  out  1  enqueue accepted when enq_valid && enq_ready
enq_bucket  in  NUM_BUCKETS_LOG  target bucket
deq_valid  in  1  dequeue request
deq_ready  out  1  dequeue accepted when deq_valid && deq_ready
deq_max  in  1  sampled on accept: 0 = lowest non-empty bucket, 1 = highest
resp_valid  out  1  one-cycle response pulse
resp_bucket  out  NUM_BUCKETS_LOG  chosen bucket; 0 when resp_empty
resp_empty  out  1  dequeue found no non-empty bucket
bitmap  out  NUM_BUCKETS  non-empty flags, bit i = (count[i] != 0)
total_count  out  COUNT_WIDTH+NUM_BUCKETS_LOG  sum of all counts
busy  out  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous and active-high: all counts 0, bitmap 0, total_count 0, FSM IDLE, resp_valid 0, resp_bucket 0, resp_empty 0, deq_ready 1, busy 0. enq_ready is combinational and therefore reads 1.
- FSM states and transitions:
  - IDLE: deq_ready = 1. On accept, latch deq_max and go to FIND.
  - FIND: register the ffs result over the current bitmap. Min mode uses the lsb output; max mode uses the msb output. Also register the zero flag. Go to COMMIT.
  - COMMIT: resp_valid = 1 with the registered index and empty flag. If not empty, decrement count[index]. Go to IDLE.
- Latency: accept at cycle T gives resp_valid at T+2. deq_ready = 0 in FIND and COMMIT, so the maximum throughput is one dequeue per 3 cycles.
- Enqueue:
  - enq_ready = (count[enq_bucket] != max). This is combinational from enq_bucket and state, and is independent of the FSM.
  - On accept, count[enq_bucket] increments at the clock edge. The bitmap and total_count update in the same cycle.
- Bitmap snapshot rule: FIND sees all enqueues accepted in cycles before FIND. An enqueue accepted in the FIND cycle itself is not visible to that search.
- Enqueue and COMMIT decrement on the same bucket in the same cycle: the count is unchanged and the bitmap stays 1. On different buckets, both updates apply.
- total_count updates by +1, -1 or 0 (net) per cycle and never wraps.
- Dequeue on empty: resp_empty = 1, resp_bucket = 0, no counter change.
- Saturation: enq_ready = 0 for a full bucket. enq_valid held against it is simply stalled; it is not an error.
- Arithmetic: counters are unsigned. A decrement is only issued when the registered zero flag = 0, and the bitmap guarantees the selected count is ≥ 1, so underflow is impossible by construction. Verification asserts this.
- rst asserted mid-FIND or mid-COMMIT: the in-flight request is dropped with no response and no counter change.
- deq_valid is don't-care outside IDLE. The requester holds it until accepted.

Decomposition:
- Package bbq_sched_pkg holds:
  - FSM state enum (IDLE, FIND, COMMIT).
  - Width localparams derived from NUM_BUCKETS_LOG and COUNT_WIDTH.
  - The counter-max constant.
- One sub-module instance: the existing ffs unit with WIDTH_LOG = NUM_BUCKETS_LOG, fed by bitmap. Its lsb, msb and zero outputs are used.
- Counters, bitmap and FSM are inline.

Test Plan:
- Reset, then dequeue in min mode → resp at accept+2 with resp_empty=1, resp_bucket=0; bitmap=0, total_count=0.
- Enqueue buckets 5, 9, 9, 2, then dequeue min three times → responses 2, 5, 9. Final bitmap = 0x0200, total_count = 1.
- With buckets 3 and 12 loaded, dequeue with deq_max=1 → resp_bucket=12. Bucket 12 count goes to 0 and bitmap bit 12 clears.
- Bucket 7 at count 255 (COUNT_WIDTH=8) → enq_ready=0 while enq_bucket=7, and the count stays 255. A COMMIT on bucket 7 then makes enq_ready=1 the next cycle.
- Bucket 4 at count 1 and empty otherwise. Dequeue min; in its COMMIT cycle enqueue to bucket 4 → count stays 1, bitmap bit 4 stays set. Enqueue to bucket 1 in the FIND cycle → response is 4, not 1.
- Assert rst during FIND → no resp_valid, counts cleared to 0, deq_ready=1 immediately after reset deasserts.
